dh_recip: RTL and testbench

//  Consumes the accumulated channel energy Dh (Q8.8, one-cycle valid pulse) from the Dh accumulator.

---
 rtl/dh_recip_pkg.sv | 17 +
 rtl/dh_recip_div_step.sv | 23 ++
 rtl/dh_recip.sv | 142 ++++++++++++++
 tb/tb_dh_recip.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dh_recip_pkg.sv
// Shared constants and FSM state type for the Dh reciprocal divider.
// The optional rounding mode is selected with DH_RECIP_ROUND_EN (see dh_recip).
package dh_pkg;

    localparam int Q  = 8;
    localparam int N  = 16;
    localparam int QW = 2 * Q + 1;

    localparam logic [N-1:0] SAT_MAX = {1'b0, {(N-1){1'b1}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/dh_recip_div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// subtract the divisor when it fits, and report the resulting quotient bit.
module div_step
    import dh_pkg::*;
#(
    parameter int W = N
) (
    input  logic [W:0]   rem,
    input  logic         next_bit,
    input  logic [W-1:0] d,
    output logic [W:0]   rem_next,
    output logic         q_bit
);

    logic [W+1:0] shifted;

    always_comb begin
        shifted  = {rem, next_bit};
        q_bit    = (shifted >= {2'b00, d});
        rem_next = shifted[W:0] - (q_bit ? {1'b0, d} : '0);
    end

endmodule

// File: rtl/dh_recip.sv
// Reciprocal 1/Dh in Q(N-Q).Q format via a fixed-latency restoring divider.
// DH_RECIP_ROUND_EN adds a guard quotient bit and rounds half up (one extra cycle).
module dh_recip #(
    parameter int Q = dh_pkg::Q,
    parameter int N = dh_pkg::N,
    localparam int QW = 2 * Q + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] Dh_in,
    input  logic         Dh_valid,
    output logic         busy,
    output logic [N-1:0] inv_out,
    output logic         inv_valid,
    output logic         inv_err,
    output logic         drop
);
    import dh_pkg::*;

`ifdef DH_RECIP_ROUND_EN
    localparam int STEPS = QW + 1;
`else
    localparam int STEPS = QW;
`endif
    localparam int CW = $clog2(STEPS);
    localparam logic [N-1:0] SAT_VAL = {1'b0, {(N-1){1'b1}}};

    state_t         state_q, state_d;
    logic [N-1:0]   d_q, d_d;
    logic [N:0]     rem_q, rem_d;
    logic [STEPS-1:0] quot_q, quot_d;
    logic [CW-1:0]  bit_cnt_q, bit_cnt_d;
    logic [N-1:0]   inv_out_q, inv_out_d;
    logic           inv_valid_q, inv_valid_d;
    logic           inv_err_q, inv_err_d;
    logic           drop_q, drop_d;

    logic [N:0]     step_rem;
    logic           step_q;
    logic           next_bit;
    logic [QW-1:0]  q_full;
    logic           d_nonpos;

    // The dividend is a single 1 at its MSB, so only the first step shifts in a 1.
    assign next_bit = (bit_cnt_q == CW'(STEPS - 1));

    div_step #(.W(N)) u_step (
        .rem      (rem_q),
        .next_bit (next_bit),
        .d        (d_q),
        .rem_next (step_rem),
        .q_bit    (step_q)
    );

    always_comb begin
`ifdef DH_RECIP_ROUND_EN
        q_full = quot_q[STEPS-1:1] + QW'(quot_q[0]);
`else
        q_full = quot_q;
`endif
        d_nonpos = d_q[N-1] || (d_q == '0);
    end

    always_comb begin
        state_d     = state_q;
        d_d         = d_q;
        rem_d       = rem_q;
        quot_d      = quot_q;
        bit_cnt_d   = bit_cnt_q;
        inv_out_d   = inv_out_q;
        inv_err_d   = inv_err_q;
        inv_valid_d = 1'b0;
        drop_d      = Dh_valid && (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (Dh_valid) begin
                    d_d       = Dh_in;
                    rem_d     = '0;
                    quot_d    = '0;
                    bit_cnt_d = CW'(STEPS - 1);
                    state_d   = DIV;
                end
            end
            DIV: begin
                rem_d  = step_rem;
                quot_d = {quot_q[STEPS-2:0], step_q};
                if (bit_cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    bit_cnt_d = bit_cnt_q - 1'b1;
                end
            end
            DONE: begin
                // Non-positive energy still runs the full divide; the result is forced here.
                if (d_nonpos || (q_full > QW'(SAT_VAL))) begin
                    inv_out_d = SAT_VAL;
                    inv_err_d = 1'b1;
                end else begin
                    inv_out_d = q_full[N-1:0];
                    inv_err_d = 1'b0;
                end
                inv_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            d_q         <= '0;
            rem_q       <= '0;
            quot_q      <= '0;
            bit_cnt_q   <= '0;
            inv_out_q   <= '0;
            inv_valid_q <= 1'b0;
            inv_err_q   <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            d_q         <= d_d;
            rem_q       <= rem_d;
            quot_q      <= quot_d;
            bit_cnt_q   <= bit_cnt_d;
            inv_out_q   <= inv_out_d;
            inv_valid_q <= inv_valid_d;
            inv_err_q   <= inv_err_d;
            drop_q      <= drop_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign inv_out   = inv_out_q;
    assign inv_valid = inv_valid_q;
    assign inv_err   = inv_err_q;
    assign drop      = drop_q;

endmodule

// File: tb/tb_dh_recip.sv
// Self-checking bench for dh_recip: fixed vectors, error cases, drop, reset abort, streaming.
module tb_dh_recip;

`ifdef DH_RECIP_ROUND_EN
    localparam int LAT = 19;
    localparam logic [15:0] EXP_06 = 16'h2AAB;
`else
    localparam int LAT = 18;
    localparam logic [15:0] EXP_06 = 16'h2AAA;
`endif

    logic        clk;
    logic        rst;
    logic [15:0] Dh_in;
    logic        Dh_valid;
    logic        busy;
    logic [15:0] inv_out;
    logic        inv_valid;
    logic        inv_err;
    logic        drop;

    int checks = 0;
    int failures = 0;
    int valid_cnt = 0;
    int drop_cnt = 0;

    logic [16:0] exp_q[$];

    dh_recip dut (
        .clk       (clk),
        .rst       (rst),
        .Dh_in     (Dh_in),
        .Dh_valid  (Dh_valid),
        .busy      (busy),
        .inv_out   (inv_out),
        .inv_valid (inv_valid),
        .inv_err   (inv_err),
        .drop      (drop)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (inv_valid === 1'b1) valid_cnt++;
        if (drop === 1'b1) drop_cnt++;
    end

    // Reference: {err, out}
    function automatic logic [16:0] ref_recip(input logic [15:0] d);
        int dv;
        int q;
        dv = int'($signed(d));
        if (dv <= 0) return {1'b1, 16'h7FFF};
`ifdef DH_RECIP_ROUND_EN
        q = (131072 / dv);
        q = (q / 2) + (q % 2);
`else
        q = 65536 / dv;
`endif
        if (q > 32767) return {1'b1, 16'h7FFF};
        return {1'b0, 16'(q)};
    endfunction

    // drivers: called at #1 after an edge; operand is sampled at the next edge (E0)
    task automatic pulse(input logic [15:0] d);
        Dh_in = d;
        Dh_valid = 1'b1;
        @(posedge clk);
        #1;
        Dh_valid = 1'b0;
        Dh_in = $urandom_range(0, 16'hFFFF);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (inv_valid !== 1'b1 && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic idle_cycles(input int k);
        for (int i = 0; i < k; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        Dh_valid = 1'b0;
        Dh_in = '0;
        idle_cycles(3);
        rst = 1'b0;
        idle_cycles(1);
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (inv_out !== 16'h0000) begin failures++; $display("FAIL reset_inv_out got=%h exp=0000", inv_out); end
        checks++; if (inv_valid !== 1'b0) begin failures++; $display("FAIL reset_inv_valid got=%b exp=0", inv_valid); end
        checks++; if (inv_err !== 1'b0) begin failures++; $display("FAIL reset_inv_err got=%b exp=0", inv_err); end
        checks++; if (drop !== 1'b0) begin failures++; $display("FAIL reset_drop got=%b exp=0", drop); end
    endtask

    task automatic test_unity();
        int n;
        logic [16:0] e;
        exp_q.push_back({1'b0, 16'h0100});
        pulse(16'h0100);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL unity_busy got=%b exp=1", busy); end
        wait_valid(n);
        checks++; if (n != LAT) begin failures++; $display("FAIL unity_latency got=%0d exp=%0d", n, LAT); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL unity_busy_done got=%b exp=0", busy); end
        e = exp_q.pop_front();
        checks++; if (inv_out !== e[15:0]) begin failures++; $display("FAIL unity_out got=%h exp=%h", inv_out, e[15:0]); end
        checks++; if (inv_err !== e[16]) begin failures++; $display("FAIL unity_err got=%b exp=%b", inv_err, e[16]); end
        idle_cycles(1);
        checks++; if (inv_valid !== 1'b0 || inv_out !== e[15:0]) begin
            failures++; $display("FAIL unity_hold valid=%b out=%h exp valid=0 out=%h", inv_valid, inv_out, e[15:0]);
        end
    endtask

    task automatic test_values();
        logic [15:0] din [6] = '{16'h0200, 16'h0080, 16'h0006, 16'h0001, 16'h0000, 16'hFF00};
        logic [16:0] dexp[6] = '{{1'b0, 16'h0080}, {1'b0, 16'h0200}, {1'b0, EXP_06},
                                 {1'b1, 16'h7FFF}, {1'b1, 16'h7FFF}, {1'b1, 16'h7FFF}};
        int n;
        logic [16:0] e;
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(dexp[i]);
            pulse(din[i]);
            wait_valid(n);
            checks++; if (n != LAT) begin failures++; $display("FAIL values_latency d=%h got=%0d exp=%0d", din[i], n, LAT); end
            e = exp_q.pop_front();
            checks++; if (inv_out !== e[15:0]) begin failures++; $display("FAIL values_out d=%h got=%h exp=%h", din[i], inv_out, e[15:0]); end
            checks++; if (inv_err !== e[16]) begin failures++; $display("FAIL values_err d=%h got=%b exp=%b", din[i], inv_err, e[16]); end
            idle_cycles(2);
        end
    endtask

    task automatic test_drop();
        int n;
        int v0;
        int d0;
        logic [16:0] e;
        v0 = valid_cnt;
        d0 = drop_cnt;
        exp_q.push_back({1'b0, 16'h0080});
        pulse(16'h0200);
        idle_cycles(4);
        pulse(16'h0040);
        checks++; if (drop !== 1'b1) begin failures++; $display("FAIL drop_pulse got=%b exp=1", drop); end
        idle_cycles(1);
        checks++; if (drop !== 1'b0) begin failures++; $display("FAIL drop_single got=%b exp=0", drop); end
        wait_valid(n);
        checks++; if (n != LAT - 6) begin failures++; $display("FAIL drop_latency got=%0d exp=%0d", n, LAT - 6); end
        e = exp_q.pop_front();
        checks++; if (inv_out !== e[15:0] || inv_err !== e[16]) begin
            failures++; $display("FAIL drop_first_result got=%b/%h exp=%b/%h", inv_err, inv_out, e[16], e[15:0]);
        end
        idle_cycles(25);
        checks++; if (valid_cnt - v0 != 1) begin failures++; $display("FAIL drop_valid_count got=%0d exp=1", valid_cnt - v0); end
        checks++; if (drop_cnt - d0 != 1) begin failures++; $display("FAIL drop_count got=%0d exp=1", drop_cnt - d0); end
        exp_q.push_back({1'b0, 16'h0400});
        pulse(16'h0040);
        wait_valid(n);
        e = exp_q.pop_front();
        checks++; if (n != LAT || inv_out !== e[15:0] || inv_err !== e[16]) begin
            failures++; $display("FAIL drop_next_accept lat=%0d out=%h err=%b exp lat=%0d out=%h err=%b", n, inv_out, inv_err, LAT, e[15:0], e[16]);
        end
        idle_cycles(2);
    endtask

    task automatic test_reset_abort();
        int n;
        int v0;
        logic [16:0] e;
        exp_q.push_back(ref_recip(16'h0003));
        pulse(16'h0003);
        idle_cycles(8);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        v0 = valid_cnt;
        checks++; if ({busy, inv_out, inv_valid, inv_err, drop} !== 20'h0) begin
            failures++; $display("FAIL abort_outputs got busy=%b out=%h v=%b err=%b drop=%b exp all 0", busy, inv_out, inv_valid, inv_err, drop);
        end
        idle_cycles(30);
        checks++; if (valid_cnt != v0) begin failures++; $display("FAIL abort_no_valid got=%0d exp=0", valid_cnt - v0); end
        exp_q.push_back(ref_recip(16'h0300));
        pulse(16'h0300);
        wait_valid(n);
        e = exp_q.pop_front();
        checks++; if (n != LAT) begin failures++; $display("FAIL abort_next_latency got=%0d exp=%0d", n, LAT); end
        checks++; if (inv_out !== e[15:0] || inv_err !== e[16]) begin
            failures++; $display("FAIL abort_next_result got=%b/%h exp=%b/%h", inv_err, inv_out, e[16], e[15:0]);
        end
        idle_cycles(2);
    endtask

    task automatic test_back_to_back();
        logic [15:0] ops[8];
        int n;
        int d0;
        logic [16:0] e;
        ops[0] = 16'h0003;
        ops[1] = 16'h7FFF;
        ops[2] = 16'h0101;
        ops[3] = 16'h0002;
        for (int i = 4; i < 8; i++) ops[i] = 16'($urandom_range(2, 16'h7FFF));
        d0 = drop_cnt;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(ref_recip(ops[i]));
            pulse(ops[i]);
            wait_valid(n);
            checks++; if (n != LAT) begin failures++; $display("FAIL b2b_latency i=%0d got=%0d exp=%0d", i, n, LAT); end
            if (exp_q.size() == 0) begin
                checks++; failures++; $display("FAIL b2b_queue i=%0d got=empty exp=entry", i);
            end else begin
                e = exp_q.pop_front();
                checks++; if (inv_out !== e[15:0] || inv_err !== e[16]) begin
                    failures++; $display("FAIL b2b_result i=%0d d=%h got=%b/%h exp=%b/%h", i, ops[i], inv_err, inv_out, e[16], e[15:0]);
                end
            end
        end
        idle_cycles(3);
        checks++; if (drop_cnt != d0) begin failures++; $display("FAIL b2b_drops got=%0d exp=0", drop_cnt - d0); end
    endtask

    initial begin
        rst = 1'b1;
        Dh_valid = 1'b0;
        Dh_in = '0;
        test_reset();
        test_unity();
        test_values();
        test_drop();
        test_reset_abort();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
